// File: rtl/jtlt_pkg.sv
// Shared definitions for the JTL chain timing model.
//   - state_t     : global INIT/RUN state encoding
//   - DEF_*       : default parameter values for the top and lane modules
//   - timer_w()   : width in bits of a counter that must reach
//                   max(MIN_SEP, BEGIN_CYCLES) without wrapping
package jtlt_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_DELAY        = 6;
  localparam int DEF_MIN_SEP      = 7;
  localparam int DEF_BEGIN_CYCLES = 8;
  localparam int DEF_CNT_W        = 8;

  // Bits needed to hold the larger of the two limits (at least 1 bit).
  function automatic int timer_w(input int min_sep, input int begin_cycles);
    int m;
    m = (min_sep > begin_cycles) ? min_sep : begin_cycles;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/jtlt_lane.sv
// One toggle-encoded SFQ lane of the JTL chain timing model.
// Optional feature macro: JTLT_ERR_CNT_EN (adds the err_cnt port/counter).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   run_en   in   high while the global FSM is in RUN
//   a        in   toggle-encoded pulse input (each level change = one pulse)
//   q        out  toggle-encoded pulse output, DELAY cycles after acceptance
//   err      out  sticky hold-violation flag
//   err_cnt  out  saturating count of dropped pulses (JTLT_ERR_CNT_EN only)
module jtlt_lane
  import jtlt_pkg::*;
#(
  parameter int DELAY   = DEF_DELAY,
  parameter int MIN_SEP = DEF_MIN_SEP
`ifdef JTLT_ERR_CNT_EN
  ,
  parameter int CNT_W   = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             a,
  output logic             q,
  output logic             err
`ifdef JTLT_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int            TW      = timer_w(MIN_SEP, 0);
  localparam logic [TW-1:0] SEP_SAT = TW'(MIN_SEP);

  logic             prev;
  logic [TW-1:0]    sep;
  logic [DELAY-1:0] dly_pipe;
  logic [DELAY-1:0] dly_next;
  logic             pulse;
  logic             accept;
  logic             drop;

  // Saturating increment: a long idle stretch parks the timer at MIN_SEP,
  // which keeps the next pulse acceptable instead of wrapping around.
  function automatic logic [TW-1:0] sep_inc(input logic [TW-1:0] v);
    return (v >= SEP_SAT) ? SEP_SAT : v + TW'(1);
  endfunction

  assign pulse  = a ^ prev;
  assign accept = run_en & pulse & (sep >= SEP_SAT);
  assign drop   = run_en & pulse & ~accept;

  if (DELAY == 1) begin : g_dly1
    always_comb dly_next = accept;
  end else begin : g_dlyn
    always_comb dly_next = {dly_pipe[DELAY-2:0], accept};
  end

  // Stage 0: edge detect / acceptance decision -> stage DELAY: output toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= 1'b0;
      sep      <= '0;
      dly_pipe <= '0;
      q        <= 1'b0;
      err      <= 1'b0;
    end else begin
      // prev tracks a in INIT too, so edges seen during INIT are consumed.
      prev     <= a;
      dly_pipe <= dly_next;
      q        <= q ^ dly_pipe[DELAY-1];
      // Holding the timer saturated outside RUN makes the first RUN pulse
      // unconditionally acceptable.
      if (!run_en)     sep <= SEP_SAT;
      else if (accept) sep <= TW'(1);
      else             sep <= sep_inc(sep);
      if (drop) err <= 1'b1;
    end
  end

`ifdef JTLT_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst)       err_cnt <= '0;
    else if (drop) err_cnt <= cnt_inc(err_cnt);
  end
`endif

endmodule

// File: rtl/jtl_chain_tmodel.sv
// Multi-lane discrete-time JTL chain timing model with startup gate,
// minimum-separation enforcement and ready indication.
// Optional feature macro: JTLT_ERR_CNT_EN (per-lane violation counters).
// Ports:
//   clk      in   clock, rising edge (one timing quantum per cycle)
//   rst      in   synchronous active-high reset
//   a        in   [CHANNELS] toggle-encoded pulse inputs
//   q        out  [CHANNELS] toggle-encoded pulse outputs
//   ready    out  high while the block is in RUN
//   err      out  [CHANNELS] sticky per-lane hold-violation flags
//   err_cnt  out  [CHANNELS*CNT_W] per-lane violation counts, lane i at
//                 [i*CNT_W +: CNT_W] (JTLT_ERR_CNT_EN only)
module jtl_chain_tmodel
  import jtlt_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DELAY        = DEF_DELAY,
  parameter int MIN_SEP      = DEF_MIN_SEP,
  parameter int BEGIN_CYCLES = DEF_BEGIN_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       a,
  output logic [CHANNELS-1:0]       q,
  output logic                      ready,
  output logic [CHANNELS-1:0]       err
`ifdef JTLT_ERR_CNT_EN
  ,
  output logic [CHANNELS*CNT_W-1:0] err_cnt
`endif
);

  localparam int TW = timer_w(MIN_SEP, BEGIN_CYCLES);

  if (CHANNELS < 1 || DELAY < 1 || MIN_SEP < 1 || BEGIN_CYCLES < 0 || CNT_W < 1)
  begin : g_bad_params
    $error("jtl_chain_tmodel: illegal parameter value");
  end

  state_t        state;
  logic [TW-1:0] init_cnt;
  logic          run_en;

  // Global INIT/RUN FSM; run_en is its registered output.
  // The move to RUN happens on the BEGIN_CYCLES-th edge with rst low
  // (on the first such edge when BEGIN_CYCLES is 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      run_en   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (int'(init_cnt) + 1 >= BEGIN_CYCLES) begin
            state  <= ST_RUN;
            run_en <= 1'b1;
          end else begin
            init_cnt <= init_cnt + TW'(1);
          end
        end
        ST_RUN: begin
          state  <= ST_RUN;
          run_en <= 1'b1;
        end
        default: begin
          state  <= ST_INIT;
          run_en <= 1'b0;
        end
      endcase
    end
  end

  assign ready = run_en;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    jtlt_lane #(
      .DELAY   (DELAY),
      .MIN_SEP (MIN_SEP)
`ifdef JTLT_ERR_CNT_EN
      ,
      .CNT_W   (CNT_W)
`endif
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .run_en  (run_en),
      .a       (a[i]),
      .q       (q[i]),
      .err     (err[i])
`ifdef JTLT_ERR_CNT_EN
      ,
      .err_cnt (err_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_jtl_chain_tmodel.sv
// Self-checking bench for jtl_chain_tmodel: directed startup/latency/
// separation/reset/saturation scenarios followed by randomized traffic,
// all compared each cycle against an edge-numbered reference model.
module tb_jtl_chain_tmodel;

  localparam int CH      = 4;
  localparam int DELAY   = 6;
  localparam int MIN_SEP = 7;
  localparam int BEGIN   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] a   = '0;
  logic [CH-1:0] q;
  logic          ready;
  logic [CH-1:0] err;
`ifdef JTLT_ERR_CNT_EN
  logic [CH*CNT_W-1:0] err_cnt;
`endif

  jtl_chain_tmodel #(
    .CHANNELS     (CH),
    .DELAY        (DELAY),
    .MIN_SEP      (MIN_SEP),
    .BEGIN_CYCLES (BEGIN),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .q       (q),
    .ready   (ready),
    .err     (err)
`ifdef JTLT_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: edges are numbered globally; a pulse accepted at
  // edge k is scheduled for emission at edge k+DELAY in a slot table.
  int            e = 0;
  logic [CH-1:0] m_q, m_err, m_prev;
  logic          m_ready;
  int            m_init;
  int            m_last [CH];
  bit            m_have [CH];
  int            m_cnt  [CH];
  bit            sched  [CH][64];

  task automatic model_edge(input logic r, input logic [CH-1:0] av);
    bit run;
    e++;
    if (r) begin
      m_q = '0; m_err = '0; m_prev = '0; m_ready = 1'b0; m_init = 0;
      for (int i = 0; i < CH; i++) begin
        m_have[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
        for (int s = 0; s < 64; s++) sched[i][s] = 0;
      end
      return;
    end
    run = m_ready;
    for (int i = 0; i < CH; i++) begin
      if (sched[i][e % 64]) begin
        m_q[i] = ~m_q[i];
        sched[i][e % 64] = 0;
      end
      if (run && (av[i] !== m_prev[i])) begin
        if (!m_have[i] || (e - m_last[i] >= MIN_SEP)) begin
          m_have[i] = 1;
          m_last[i] = e;
          sched[i][(e + DELAY) % 64] = 1;
        end else begin
          m_err[i] = 1'b1;
          if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
        end
      end
      m_prev[i] = av[i];
      if (!run) m_have[i] = 0;
    end
    if (!run) begin
      m_init++;
      if (m_init >= BEGIN) m_ready = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("q", q, m_q);
    check("err", err, m_err);
    check("ready", ready, m_ready);
`ifdef JTLT_ERR_CNT_EN
    for (int i = 0; i < CH; i++)
      check($sformatf("err_cnt%0d", i), err_cnt[i*CNT_W +: CNT_W], 64'(m_cnt[i]));
`endif
  endtask

  task automatic cyc(input logic r, input logic [CH-1:0] av);
    @(negedge clk);
    rst = r;
    a   = av;
    @(posedge clk);
    model_edge(r, av);
    #1;
    compare_all();
  endtask

  logic [CH-1:0] lvl;
  logic [CH-1:0] tgl;
  int            rst_hold;

  initial begin
    lvl = '0;
    // Directed timeline, edge k is the k-th rising edge of the run.
    for (int k = 1; k <= 75; k++) begin
      case (k)
        3:          lvl[0] = ~lvl[0];
        20:         lvl[1] = ~lvl[1];
        30, 37, 43: lvl[2] = ~lvl[2];
        50:         lvl    = ~lvl;
        60:         lvl[3] = ~lvl[3];
        default: ;
      endcase
      cyc((k <= 2) || (k == 63), lvl);
      case (k)
        3:  begin check("gate_q", q, 4'b0000); check("gate_err", err, 4'b0000); end
        9:  check("ready_early", ready, 1'b0);
        10: check("ready_rise", ready, 1'b1);
        25: check("lat_before", q, 4'b0000);
        26: check("lat_q1", q, 4'b0010);
        36: check("sep_first", q, 4'b0110);
        43: begin
          check("sep_second", q, 4'b0010);
          check("sep_err", err, 4'b0100);
`ifdef JTLT_ERR_CNT_EN
          check("sep_cnt2", err_cnt[2*CNT_W +: CNT_W], 1);
`endif
        end
        56: check("simul_q", q, 4'b1101);
        63: begin
          check("rst_q", q, 4'b0000);
          check("rst_err", err, 4'b0000);
          check("rst_ready", ready, 1'b0);
        end
        66: check("rst_noemit", q, 4'b0000);
        default: ;
      endcase
    end

    // Counter saturation: one accepted pulse, then five back-to-back drops.
    lvl[0] = ~lvl[0];
    cyc(1'b0, lvl);
    for (int n = 0; n < 5; n++) begin
      lvl[0] = ~lvl[0];
      cyc(1'b0, lvl);
    end
    check("sat_err0", err[0], 1'b1);
`ifdef JTLT_ERR_CNT_EN
    check("sat_cnt0", err_cnt[1:0], 2'd3);
`endif
    for (int n = 0; n < 3; n++) cyc(1'b0, lvl);
`ifdef JTLT_ERR_CNT_EN
    check("sat_hold0", err_cnt[1:0], 2'd3);
`endif

    // Randomized traffic with occasional multi-cycle resets.
    rst_hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst_hold == 0 && $urandom_range(399) == 0) rst_hold = $urandom_range(3, 1);
      tgl = '0;
      for (int i = 0; i < CH; i++)
        if ($urandom_range(5) == 0) tgl[i] = 1'b1;
      lvl = lvl ^ tgl;
      cyc(rst_hold != 0, lvl);
      if (rst_hold != 0) rst_hold--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
